// File: rtl/pmem_loader_pkg.sv
// Shared definitions for the boot-time program loader: word geometry,
// header length and the loader state encoding.
package pmem_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  // The header is a single little-endian word holding the word count.
  localparam int unsigned HDR_BYTES      = BYTES_PER_WORD;

  // State encoding kept as plain vector constants so older tools and
  // netlist viewers see stable codes.
  typedef logic [2:0] loader_state_e;

  localparam loader_state_e ST_IDLE  = 3'd0;
  localparam loader_state_e ST_HDR   = 3'd1;
  localparam loader_state_e ST_DATA  = 3'd2;
  localparam loader_state_e ST_WRITE = 3'd3;
  localparam loader_state_e ST_CSUM  = 3'd4;
  localparam loader_state_e ST_DONE  = 3'd5;

endpackage

// File: rtl/pmem_loader_if.sv
// PMEM write port between the loader (master) and program memory (slave).
// PMEM always accepts, so the port is a bare strobe with data and word index.
interface pmem_loader_if #(
  parameter int unsigned ADDR_W = 32
);

  logic              ic1_c_axi_mst_wr_valid;
  logic [31:0]       ic1_axi_mst_wr_data;
  logic [ADDR_W-1:0] ic1_axi_mst_wr_addr;

  modport master (
    output ic1_c_axi_mst_wr_valid,
    output ic1_axi_mst_wr_data,
    output ic1_axi_mst_wr_addr
  );

  modport slave (
    input ic1_c_axi_mst_wr_valid,
    input ic1_axi_mst_wr_data,
    input ic1_axi_mst_wr_addr
  );

endinterface

// File: rtl/pmem_loader_byte_word_packer.sv
// Little-endian byte-to-word packer. The first byte lands in bits 7:0.
// word_o is the combinational word formed by the bytes collected so far plus
// the byte on the input; word_valid_o pulses in the cycle the last byte of a
// word is accepted, so the consumer can act on the word at that same edge.
module byte_word_packer
  import pmem_loader_pkg::*;
#(
  parameter int unsigned NBYTES = BYTES_PER_WORD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_i,
  output logic [8*NBYTES-1:0]   word_o,
  output logic                  word_valid_o
);

  localparam int unsigned CntW  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned WordW = 8 * NBYTES;

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WordW-9:0] shift_q, shift_d;
  logic             lastByte;

  assign lastByte     = (cnt_q == CntW'(NBYTES - 1));
  assign word_o       = {byte_i, shift_q};
  assign word_valid_o = byte_valid_i & lastByte;

  // Shift each accepted byte in from the top; restart counting on clear or
  // after a complete word.
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clear_i) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (byte_valid_i) begin
      shift_d = word_o[WordW-1:8];
      cnt_d   = lastByte ? '0 : cnt_q + 1'b1;
    end
  end

  // Byte counter and partial-word storage; reset discards any partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/pmem_loader.sv
// Boot-time program loader. Reads a byte stream (LE word count N followed by
// N LE instruction words), writes word k to PMEM word index BASE_ADDR+k and
// keeps the core in reset until a load finishes without error.
// Optional feature macro: PMEM_LOADER_CSUM_EN -- when defined, the stream
// carries a trailing LE 32-bit checksum (sum of the data words mod 2^32) that
// must match for the load to release the core.
module pmem_loader
  import pmem_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       MAX_WORDS = 512,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  output logic                rx_ready,
  pmem_loader_if.master       wr,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                core_rst
);

  loader_state_e     state_q, state_d;
  logic [31:0]       nWords_q, nWords_d;
  logic [31:0]       wordIdx_q, wordIdx_d;
  logic              wrValid_q, wrValid_d;
  logic [31:0]       wrData_q, wrData_d;
  logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              coreRst_q, coreRst_d;
`ifdef PMEM_LOADER_CSUM_EN
  logic [31:0]       csum_q, csum_d;
`endif

  logic              byteFire;
  logic              packClear;
  logic [31:0]       word;
  logic              wordValid;

  assign rx_ready  = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign byteFire  = rx_valid & rx_ready;
  assign packClear = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  assign busy     = (state_q == ST_HDR) || (state_q == ST_DATA) ||
                    (state_q == ST_WRITE) || (state_q == ST_CSUM);
  assign done     = done_q;
  assign err      = err_q;
  assign core_rst = coreRst_q;

  assign wr.ic1_c_axi_mst_wr_valid = wrValid_q;
  assign wr.ic1_axi_mst_wr_data    = wrData_q;
  assign wr.ic1_axi_mst_wr_addr    = wrAddr_q;

  // One packer serves the header, the data words and the checksum word.
  byte_word_packer #(
    .NBYTES (HDR_BYTES)
  ) u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (packClear),
    .byte_valid_i (byteFire),
    .byte_i       (rx_data),
    .word_o       (word),
    .word_valid_o (wordValid)
  );

  // Load sequencing: header decode, per-word write strobes, optional
  // checksum verification and the sticky done/err/core-reset status.
  always_comb begin
    state_d   = state_q;
    nWords_d  = nWords_q;
    wordIdx_d = wordIdx_q;
    wrValid_d = 1'b0;
    wrData_d  = wrData_q;
    wrAddr_d  = wrAddr_q;
    done_d    = done_q;
    err_d     = err_q;
    coreRst_d = coreRst_q;
`ifdef PMEM_LOADER_CSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_HDR;
          done_d    = 1'b0;
          err_d     = 1'b0;
          coreRst_d = 1'b1;
          wordIdx_d = '0;
`ifdef PMEM_LOADER_CSUM_EN
          csum_d    = '0;
`endif
        end
      end
      ST_HDR: begin
        if (wordValid) begin
          nWords_d = word;
          if (word == 32'd0) begin
`ifdef PMEM_LOADER_CSUM_EN
            state_d   = ST_CSUM;
`else
            state_d   = ST_DONE;
            done_d    = 1'b1;
            coreRst_d = 1'b0;
`endif
          end else if (word > 32'(MAX_WORDS)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (wordValid) begin
          state_d   = ST_WRITE;
          wrValid_d = 1'b1;
          wrData_d  = word;
          wrAddr_d  = BASE_ADDR + ADDR_W'(wordIdx_q);
`ifdef PMEM_LOADER_CSUM_EN
          csum_d    = csum_q + word;
`endif
        end
      end
      ST_WRITE: begin
        wordIdx_d = wordIdx_q + 32'd1;
        if (wordIdx_d == nWords_q) begin
`ifdef PMEM_LOADER_CSUM_EN
          state_d   = ST_CSUM;
`else
          state_d   = ST_DONE;
          done_d    = 1'b1;
          coreRst_d = 1'b0;
`endif
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef PMEM_LOADER_CSUM_EN
      ST_CSUM: begin
        if (wordValid) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          err_d     = (word != csum_q);
          coreRst_d = (word != csum_q);
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any load in progress and
  // holds the core in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      nWords_q  <= '0;
      wordIdx_q <= '0;
      wrValid_q <= 1'b0;
      wrData_q  <= '0;
      wrAddr_q  <= BASE_ADDR;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      coreRst_q <= 1'b1;
`ifdef PMEM_LOADER_CSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      nWords_q  <= nWords_d;
      wordIdx_q <= wordIdx_d;
      wrValid_q <= wrValid_d;
      wrData_q  <= wrData_d;
      wrAddr_q  <= wrAddr_d;
      done_q    <= done_d;
      err_q     <= err_d;
      coreRst_q <= coreRst_d;
`ifdef PMEM_LOADER_CSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_pmem_loader.sv
// Self-checking bench for pmem_loader: directed and randomized loads compared
// against a stream-level reference model of expected writes and status.
module tb_pmem_loader;

  localparam int unsigned MAX_WORDS = 512;
  localparam logic [31:0] BASE_ADDR = 32'd0;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       busy;
  logic       done;
  logic       err;
  logic       core_rst;

  pmem_loader_if #(.ADDR_W(32)) wrIf ();

  pmem_loader #(
    .ADDR_W    (32),
    .MAX_WORDS (MAX_WORDS),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .wr       (wrIf),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .core_rst (core_rst)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int          nChecks = 0;
  int          nFails  = 0;
  int          busyCyc;
  int          readyViol;
  logic [31:0] obsAddr[$];
  logic [31:0] obsData[$];
  logic [31:0] expAddr[$];
  logic [31:0] expData[$];
  logic        expErr;
  int          expBusy;
  logic [7:0]  txBytes[$];
  logic [31:0] words[$];

  // Record every PMEM write and flag any write cycle that still offers rx_ready.
  always @(negedge clk) begin
    if (wrIf.ic1_c_axi_mst_wr_valid === 1'b1) begin
      obsAddr.push_back(wrIf.ic1_axi_mst_wr_addr);
      obsData.push_back(wrIf.ic1_axi_mst_wr_data);
      if (rx_ready !== 1'b0) readyViol++;
    end
    if (busy === 1'b1) busyCyc++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic pushWord(input logic [31:0] w);
    for (int b = 0; b < 4; b++) txBytes.push_back(w[8*b +: 8]);
  endtask

  // Reference model: derive the byte stream, expected writes, error flag and
  // busy duration (header 4 cycles, 5 per word, 4 for a checksum) from N and words.
  task automatic buildLoad(input int unsigned n, input logic [31:0] csumDelta);
    logic [31:0] sum;
    sum = 32'd0;
    txBytes.delete();
    expAddr.delete();
    expData.delete();
    pushWord(n);
    if (n > MAX_WORDS) begin
      expErr  = 1'b1;
      expBusy = 4;
    end else begin
      for (int k = 0; k < int'(n); k++) begin
        pushWord(words[k]);
        expAddr.push_back(BASE_ADDR + k);
        expData.push_back(words[k]);
        sum += words[k];
      end
      expBusy = 4 + 5 * int'(n);
`ifdef PMEM_LOADER_CSUM_EN
      pushWord(sum + csumDelta);
      expErr  = (csumDelta != 32'd0);
      expBusy += 4;
`else
      expErr  = 1'b0;
`endif
    end
  endtask

  task automatic resetObs();
    obsAddr.delete();
    obsData.delete();
    busyCyc   = 0;
    readyViol = 0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Send txBytes[first..last-1]; mode 0 back-to-back, 1 one idle cycle per byte, 2 random idles.
  task automatic applyStimulus(input int mode, input int first, input int last);
    bit ok;
    for (int i = first; i < last; i++) begin
      if (mode != 0) begin
        rx_valid = 1'b0;
        repeat ((mode == 1) ? 1 : $urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
      rx_valid = 1'b1;
      rx_data  = txBytes[i];
      ok = 1'b0;
      for (int c = 0; c < 200 && !ok; c++) begin
        @(negedge clk);
        if (rx_ready === 1'b1) ok = 1'b1;
        @(posedge clk); #1;
      end
      rx_valid = 1'b0;
      if (!ok) begin
        checkOutput("rxAcceptTimeout", 32'd0, 32'd1);
        return;
      end
    end
  endtask

  // Wait (bounded) for done, then compare status and the write log with the model.
  task automatic finishLoad(input string tag, input bit checkLat);
    int nCmp;
    for (int c = 0; c < 100 && done !== 1'b1; c++) begin
      @(posedge clk); #1;
    end
    checkOutput({tag, ".done"}, done, 1'b1);
    checkOutput({tag, ".err"}, err, expErr);
    checkOutput({tag, ".coreRst"}, core_rst, expErr);
    checkOutput({tag, ".busy"}, busy, 1'b0);
    checkOutput({tag, ".wrCount"}, obsAddr.size(), expAddr.size());
    checkOutput({tag, ".readyInWrite"}, readyViol, 0);
    if (checkLat) checkOutput({tag, ".busyCycles"}, busyCyc, expBusy);
    nCmp = (obsAddr.size() < expAddr.size()) ? obsAddr.size() : expAddr.size();
    for (int k = 0; k < nCmp; k++) begin
      checkOutput($sformatf("%s.addr[%0d]", tag, k), obsAddr[k], expAddr[k]);
      checkOutput($sformatf("%s.data[%0d]", tag, k), obsData[k], expData[k]);
    end
  endtask

  task automatic doLoad(input string tag, input int mode);
    resetObs();
    pulseStart();
    applyStimulus(mode, 0, txBytes.size());
    finishLoad(tag, mode == 0);
  endtask

  initial begin
    int unsigned n;
    rst      = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    checkOutput("rst.rxReady", rx_ready, 1'b0);
    checkOutput("rst.wrValid", wrIf.ic1_c_axi_mst_wr_valid, 1'b0);
    checkOutput("rst.wrData", wrIf.ic1_axi_mst_wr_data, 32'd0);
    checkOutput("rst.wrAddr", wrIf.ic1_axi_mst_wr_addr, BASE_ADDR);
    checkOutput("rst.busy", busy, 1'b0);
    checkOutput("rst.done", done, 1'b0);
    checkOutput("rst.err", err, 1'b0);
    checkOutput("rst.coreRst", core_rst, 1'b1);

    // Two-word load, back-to-back bytes.
    words = '{32'h0000_0013, 32'h1234_5678};
    buildLoad(2, 32'd0);
    doLoad("basic", 0);

    // Same stream with rx_valid toggling.
    doLoad("toggle", 1);

    // Empty program and oversize header.
    buildLoad(0, 32'd0);
    doLoad("nZero", 0);
    buildLoad(MAX_WORDS + 1, 32'd0);
    doLoad("nOver", 0);

    // Reset after six bytes of a two-word load.
    words = '{32'hA5A5_0F0F, 32'hDEAD_BEEF};
    buildLoad(2, 32'd0);
    resetObs();
    pulseStart();
    applyStimulus(0, 0, 6);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    checkOutput("midRst.busy", busy, 1'b0);
    checkOutput("midRst.rxReady", rx_ready, 1'b0);
    checkOutput("midRst.done", done, 1'b0);
    checkOutput("midRst.coreRst", core_rst, 1'b1);
    checkOutput("midRst.wrCount", obsAddr.size(), 0);
    doLoad("afterRst", 0);

    // Start and reset together: reset wins.
    start = 1'b1;
    rst   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rst   = 1'b0;
    checkOutput("rstStart.busy", busy, 1'b0);
    checkOutput("rstStart.done", done, 1'b0);
    checkOutput("rstStart.coreRst", core_rst, 1'b1);

    // Start pulsed while in DATA is ignored.
    words = '{$urandom, $urandom, $urandom};
    buildLoad(3, 32'd0);
    resetObs();
    pulseStart();
    applyStimulus(0, 0, 9);
    pulseStart();
    checkOutput("midStart.busy", busy, 1'b1);
    applyStimulus(0, 9, txBytes.size());
    finishLoad("midStart", 1'b0);

    // Randomized loads with random pacing.
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(1, 9);
      words.delete();
      for (int k = 0; k < int'(n); k++) words.push_back($urandom);
      buildLoad(n, 32'd0);
      doLoad($sformatf("rand%0d", r), $urandom_range(0, 2));
    end

    // Largest accepted program.
    words.delete();
    for (int k = 0; k < int'(MAX_WORDS); k++) words.push_back($urandom);
    buildLoad(MAX_WORDS, 32'd0);
    doLoad("nMax", 0);

`ifdef PMEM_LOADER_CSUM_EN
    // Checksum good and bad.
    words = '{32'h0000_0013, 32'h1234_5678};
    buildLoad(2, 32'd0);
    doLoad("csumGood", 0);
    buildLoad(2, 32'd1);
    doLoad("csumBad", 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
